ctrl_mc: RTL
============

CTRL_MC -- requirements
Module: ctrl_mc

Interface
REQ-001 SHALL provide parameter N_IRQ, default 4, number of interrupt lines (1..16).
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 15, bus-wait cycles before fault (1..255).
REQ-003 SHALL provide ports in this order:
  CLK  in  1  clock; one clock domain, rising edge.
  RES  in  1  reset; synchronous, active-high.
  opcode  in  7  instruction opcode field.
  instr_req  out  1  instruction fetch request.
  instr_gnt  in  1  fetch request granted.
  instr_r_valid  in  1  fetch data valid.
  data_req  out  1  data memory request.
  data_write_enable  out  1  0 read, 1 write.
  data_gnt  in  1  data request granted.
  data_r_valid  in  1  read data valid or write acknowledge.
  pc_enable  out  1  PC update strobe.
  pc_mode  out  3  0 +4, 1 PC+imm, 2 Q0+imm, 3 irq vector, 4 restore backup.
  alu_a_sel  out  2  0 Q0, 1 PC, 2 zero.
  alu_b_sel  out  2  0 Q1, 1 immediate, 2 constant 4.
  ALUOp  out  2  ALU operation class.
  write_enable  out  1  register-set write.
  alu_dm_select  out  1  0 ALU result, 1 data memory.
  irq  in  N_IRQ  level interrupt requests.
  irq_mask  in  N_IRQ  1 = line enabled.
  irq_status  in  1  1 = ISR active.
  irq_status_update  out  1  load irq_context into status.
  irq_context  out  1  1 entering ISR, 0 leaving.
  bckup_reg  out  1  save PC to backup register.
  irq_ack  out  1  one-cycle acknowledge.
  irq_ack_id  out  max(1,clog2(N_IRQ))  acknowledged line index.
  bus_fault  out  1  one-cycle bus-timeout pulse.

Function
REQ-004 SHALL implement states READY, IFETCH, EXEC, WB, DREAD, DWRITE, IRQ_ENTER, IRQ_ACK; all outputs decoded from state plus inputs, default 0.
REQ-005 SHALL, in READY, go to IRQ_ENTER with instr_req=0 when (irq & irq_mask)!=0 and irq_status=0; else assert instr_req and go to IFETCH on instr_gnt.
REQ-006 SHALL sample interrupts only in READY (precise); IFETCH waits for instr_r_valid and then goes to EXEC; interrupts deasserted before READY are dropped.
REQ-007 SHALL decode in EXEC for one cycle:
  LUI: zero/imm, ALUOp 10, write_enable, go to WB.
  AUIPC: PC/imm, ALUOp 10, write_enable, go to WB.
  OP-IMM: Q0/imm, ALUOp 00, write_enable, go to WB.
  OP: Q0/Q1, ALUOp 01, write_enable, go to WB.
  JAL: PC/4, ALUOp 11, write_enable, pc_mode 1, go to WB.
  JALR: PC/4, ALUOp 10, write_enable, pc_mode 2, go to WB.
  BRANCH: Q0/Q1, ALUOp 11, pc_enable, pc_mode 1, go to READY.
  LOAD: Q0/imm, ALUOp 00, data_req held until data_gnt, then go to DREAD.
  STORE: Q0/imm, ALUOp 01, data_req and data_write_enable held until data_gnt, then go to DWRITE.
  1110011 (MRET): pc_enable, pc_mode 4, irq_status_update, irq_context 0, go to READY.
  Any other opcode: pc_enable, pc_mode 0 (skip illegal instruction), go to READY.
REQ-008 SHALL register the EXEC pc_mode and present it with pc_enable=1 for one cycle in WB, then go to READY.
REQ-009 SHALL, in DREAD, hold LOAD selects; on data_r_valid assert write_enable and alu_dm_select, then go to WB.
REQ-010 SHALL, in DWRITE, wait for data_r_valid, then assert pc_enable with pc_mode 0 and go to READY.
REQ-011 SHALL, in IRQ_ENTER, latch the lowest-index pending unmasked line and assert pc_enable, pc_mode 3, bckup_reg, irq_status_update, irq_context=1, then go to IRQ_ACK.
REQ-012 SHALL, in IRQ_ACK, assert irq_ack with irq_ack_id equal to the latched index for exactly one cycle, then go to READY.

Reset
REQ-013 SHALL, while RES=1 at a clock edge: state READY, latched id 0, timeout counter 0, all outputs 0; any in-flight transaction is abandoned without pc_enable.

Configuration
REQ-014 SHALL, with CTRL_BUS_TIMEOUT_EN defined, count consecutive cycles waiting on instr_gnt, instr_r_valid, data_gnt or data_r_valid; on reaching TIMEOUT_CYC, pulse bus_fault, drop requests, return to READY with no PC update, and clear the counter on every state change. Without the macro, bus_fault=0, no counter is built, and waits are unbounded.

Structure
REQ-015 SHALL place the state encoding (3-bit), opcode constants, and pc_mode/alu_a_sel/alu_b_sel encodings in package ctrl_mc_pkg.
REQ-016 SHALL use a sub-module irq_prio_enc (N_IRQ-wide lowest-index priority encoder with valid flag).

Verification
REQ-017 Directed scenarios the bench SHALL cover:
  ADDI, gnt and r_valid immediate -> write_enable in EXEC; pc_enable, pc_mode 0 in WB; READY at cycle 4.
  LW with data_gnt delayed 3 cycles and r_valid 2 more -> data_req high 4 cycles; write_enable+alu_dm_select in the r_valid cycle.
  irq=4'b1010, mask=4'b1111, in READY -> IRQ_ENTER; irq_ack_id=1; no instr_req that cycle.
  irq raised during DREAD, irq_status=1 -> not taken; MRET -> pc_mode 4, irq_context 0, then irq taken.
  CTRL_BUS_TIMEOUT_EN, TIMEOUT_CYC=15, instr_gnt stuck 0 -> bus_fault after 15 cycles, no pc_enable.
  RES asserted in DREAD -> next cycle state READY, all outputs 0.

Source files
------------

// File: rtl/ctrl_mc_pkg.sv
// Shared encodings for the ctrl_mc multi-cycle controller: FSM states, opcodes and mux selects.
package ctrl_mc_pkg;

  typedef enum logic [2:0] {
    StReady    = 3'd0,
    StIfetch   = 3'd1,
    StExec     = 3'd2,
    StWb       = 3'd3,
    StDread    = 3'd4,
    StDwrite   = 3'd5,
    StIrqEnter = 3'd6,
    StIrqAck   = 3'd7
  } state_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpMret   = 7'b1110011;

  localparam logic [2:0] PcPlus4   = 3'd0;
  localparam logic [2:0] PcRel     = 3'd1;
  localparam logic [2:0] PcReg     = 3'd2;
  localparam logic [2:0] PcIrq     = 3'd3;
  localparam logic [2:0] PcRestore = 3'd4;

  localparam logic [1:0] ASelQ0   = 2'd0;
  localparam logic [1:0] ASelPc   = 2'd1;
  localparam logic [1:0] ASelZero = 2'd2;

  localparam logic [1:0] BSelQ1   = 2'd0;
  localparam logic [1:0] BSelImm  = 2'd1;
  localparam logic [1:0] BSelFour = 2'd2;

  localparam logic [1:0] AluC00 = 2'b00;
  localparam logic [1:0] AluC01 = 2'b01;
  localparam logic [1:0] AluC10 = 2'b10;
  localparam logic [1:0] AluC11 = 2'b11;

  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the active interrupt lines.
module irq_prio_enc
  import ctrl_mc_pkg::*;
#(
  parameter int unsigned  N   = 4,
  localparam int unsigned IdW = id_width(N)
) (
  input  logic [N-1:0]   i_req,
  output logic [IdW-1:0] o_id,
  output logic           o_valid
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    o_id    = '0;
    o_valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_id    = IdW'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_mc.sv
// Multi-cycle control FSM: fetch, execute, memory, write-back and precise interrupt entry.
// Define CTRL_BUS_TIMEOUT_EN to build the bus-wait watchdog that drives bus_fault.
module ctrl_mc
  import ctrl_mc_pkg::*;
#(
  parameter int unsigned  N_IRQ       = 4,
  parameter int unsigned  TIMEOUT_CYC = 15,
  localparam int unsigned IdW         = id_width(N_IRQ)
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic [6:0]       opcode,
  output logic             instr_req,
  input  logic             instr_gnt,
  input  logic             instr_r_valid,
  output logic             data_req,
  output logic             data_write_enable,
  input  logic             data_gnt,
  input  logic             data_r_valid,
  output logic             pc_enable,
  output logic [2:0]       pc_mode,
  output logic [1:0]       alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [1:0]       ALUOp,
  output logic             write_enable,
  output logic             alu_dm_select,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             irq_status,
  output logic             irq_status_update,
  output logic             irq_context,
  output logic             bckup_reg,
  output logic             irq_ack,
  output logic [IdW-1:0]   irq_ack_id,
  output logic             bus_fault
);

  state_e           r_state, w_state_nxt;
  logic [2:0]       r_pc_mode;
  logic [IdW-1:0]   r_irq_id, w_enc_id;
  logic [N_IRQ-1:0] w_irq_act;
  logic             w_enc_valid, w_irq_pend, w_fault;

  assign w_irq_act  = irq & irq_mask;
  assign w_irq_pend = w_enc_valid & ~irq_status;

  irq_prio_enc #(.N(N_IRQ)) u_prio (
    .i_req  (w_irq_act),
    .o_id   (w_enc_id),
    .o_valid(w_enc_valid)
  );

`ifdef CTRL_BUS_TIMEOUT_EN
  logic       w_wait;
  logic [7:0] r_cnt;

  // A cycle counts only while the FSM is stalled on a bus handshake.
  assign w_wait = !RES && (
      (r_state == StReady  && !w_irq_pend && !instr_gnt) ||
      (r_state == StIfetch && !instr_r_valid) ||
      (r_state == StExec   && (opcode == OpLoad || opcode == OpStore) && !data_gnt) ||
      ((r_state == StDread || r_state == StDwrite) && !data_r_valid));
  assign w_fault = w_wait && (r_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (RES)                     r_cnt <= '0;
    else if (w_wait && !w_fault) r_cnt <= r_cnt + 8'd1;
    else                         r_cnt <= '0;
  end
`else
  assign w_fault = 1'b0;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    instr_req         = 1'b0;
    data_req          = 1'b0;
    data_write_enable = 1'b0;
    pc_enable         = 1'b0;
    pc_mode           = PcPlus4;
    alu_a_sel         = ASelQ0;
    alu_b_sel         = BSelQ1;
    ALUOp             = AluC00;
    write_enable      = 1'b0;
    alu_dm_select     = 1'b0;
    irq_status_update = 1'b0;
    irq_context       = 1'b0;
    bckup_reg         = 1'b0;
    irq_ack           = 1'b0;
    irq_ack_id        = '0;
    bus_fault         = 1'b0;
    if (RES) begin
      w_state_nxt = StReady;
    end else begin
      unique case (r_state)
        StReady: begin
          if (w_irq_pend) begin
            w_state_nxt = StIrqEnter;
          end else begin
            instr_req = 1'b1;
            if (instr_gnt) w_state_nxt = StIfetch;
          end
        end
        StIfetch: if (instr_r_valid) w_state_nxt = StExec;
        StExec: begin
          case (opcode)
            OpLui: begin
              alu_a_sel = ASelZero; alu_b_sel = BSelImm; ALUOp = AluC10;
              write_enable = 1'b1; w_state_nxt = StWb;
            end
            OpAuipc: begin
              alu_a_sel = ASelPc; alu_b_sel = BSelImm; ALUOp = AluC10;
              write_enable = 1'b1; w_state_nxt = StWb;
            end
            OpOpImm: begin
              alu_a_sel = ASelQ0; alu_b_sel = BSelImm; ALUOp = AluC00;
              write_enable = 1'b1; w_state_nxt = StWb;
            end
            OpOp: begin
              alu_a_sel = ASelQ0; alu_b_sel = BSelQ1; ALUOp = AluC01;
              write_enable = 1'b1; w_state_nxt = StWb;
            end
            OpJal: begin
              alu_a_sel = ASelPc; alu_b_sel = BSelFour; ALUOp = AluC11;
              write_enable = 1'b1; pc_mode = PcRel; w_state_nxt = StWb;
            end
            OpJalr: begin
              alu_a_sel = ASelPc; alu_b_sel = BSelFour; ALUOp = AluC10;
              write_enable = 1'b1; pc_mode = PcReg; w_state_nxt = StWb;
            end
            OpBranch: begin
              alu_a_sel = ASelQ0; alu_b_sel = BSelQ1; ALUOp = AluC11;
              pc_enable = 1'b1; pc_mode = PcRel; w_state_nxt = StReady;
            end
            OpLoad: begin
              alu_a_sel = ASelQ0; alu_b_sel = BSelImm; ALUOp = AluC00;
              data_req = 1'b1;
              if (data_gnt) w_state_nxt = StDread;
            end
            OpStore: begin
              alu_a_sel = ASelQ0; alu_b_sel = BSelImm; ALUOp = AluC01;
              data_req = 1'b1; data_write_enable = 1'b1;
              if (data_gnt) w_state_nxt = StDwrite;
            end
            OpMret: begin
              pc_enable = 1'b1; pc_mode = PcRestore; irq_status_update = 1'b1;
              irq_context = 1'b0; w_state_nxt = StReady;
            end
            // Illegal opcodes are skipped by stepping the PC.
            default: begin
              pc_enable = 1'b1; pc_mode = PcPlus4; w_state_nxt = StReady;
            end
          endcase
        end
        StWb: begin
          pc_enable = 1'b1; pc_mode = r_pc_mode; w_state_nxt = StReady;
        end
        StDread: begin
          alu_a_sel = ASelQ0; alu_b_sel = BSelImm; ALUOp = AluC00;
          if (data_r_valid) begin
            write_enable = 1'b1; alu_dm_select = 1'b1; w_state_nxt = StWb;
          end
        end
        StDwrite: begin
          if (data_r_valid) begin
            pc_enable = 1'b1; pc_mode = PcPlus4; w_state_nxt = StReady;
          end
        end
        StIrqEnter: begin
          pc_enable = 1'b1; pc_mode = PcIrq; bckup_reg = 1'b1;
          irq_status_update = 1'b1; irq_context = 1'b1; w_state_nxt = StIrqAck;
        end
        StIrqAck: begin
          irq_ack = 1'b1; irq_ack_id = r_irq_id; w_state_nxt = StReady;
        end
        default: w_state_nxt = StReady;
      endcase
      if (w_fault) begin
        instr_req = 1'b0; data_req = 1'b0; data_write_enable = 1'b0;
        bus_fault = 1'b1; w_state_nxt = StReady;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state   <= StReady;
      r_pc_mode <= PcPlus4;
      r_irq_id  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StExec)     r_pc_mode <= pc_mode;
      if (r_state == StIrqEnter) r_irq_id  <= w_enc_id;
    end
  end

endmodule
